ysyx_24090012_sram_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single SRAM valid/ready port between the IFU (instruction fetch, read-only) and the LSU (loads and stores). It sits between those two requesters and `ysyx_24090012_SRAM`. It serialises their transactions, routes each response back to the requester that owns the grant, and bounds every transaction with a watchdog timeout.

---
 rtl/ysyx_24090012_sram_arbiter.sv | 76 +++++++
 tb/tb_ysyx_24090012_sram_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090012_sram_arbiter.sv
// ysyx_24090012_sram_arbiter: round-robin arbiter sharing one SRAM valid/ready port
// between IFU and LSU, with a per-transaction watchdog.
module ysyx_24090012_sram_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ifu_valid,
    input  logic [31:0] i_ifu_addr,
    output logic        o_ifu_ready,
    output logic [31:0] o_ifu_rdata,
    input  logic        i_lsu_valid,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    input  logic [3:0]  i_lsu_wmask,
    input  logic        i_lsu_wen,
    output logic        o_lsu_ready,
    output logic [31:0] o_lsu_rdata,
    output logic        o_sram_valid,
    output logic [31:0] o_sram_addr,
    output logic [31:0] o_sram_wdata,
    output logic [3:0]  o_sram_wmask,
    output logic        o_sram_wen,
    input  logic        i_sram_ready,
    input  logic [31:0] i_sram_rdata,
    output logic        o_busy,
    output logic        o_timeout
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_LSU} state_t;
    state_t         r_state;
    logic           r_last;
    logic [W-1:0]   r_cnt;
    logic           w_ifu, w_lsu, w_expire, w_fin, w_done;
    always_comb begin
        w_ifu        = r_state == GNT_IFU;
        w_lsu        = r_state == GNT_LSU;
        w_expire     = (TIMEOUT > 0) && (r_cnt == LAST) && !i_sram_ready;
        w_fin        = (w_ifu || w_lsu) && (i_sram_ready || w_expire);
        // a reset landing mid-grant must swallow the response strobe
        w_done       = w_fin && !rst;
        o_busy       = w_ifu || w_lsu;
        o_sram_valid = w_ifu || w_lsu;
        o_sram_addr  = w_ifu ? i_ifu_addr : (w_lsu ? i_lsu_addr : '0);
        o_sram_wdata = w_lsu ? i_lsu_wdata : '0;
        o_sram_wmask = w_lsu ? i_lsu_wmask : '0;
        o_sram_wen   = w_lsu && i_lsu_wen;
        o_ifu_ready  = w_ifu && w_done;
        o_lsu_ready  = w_lsu && w_done;
        o_ifu_rdata  = (o_ifu_ready && i_sram_ready) ? i_sram_rdata : '0;
        o_lsu_rdata  = (o_lsu_ready && i_sram_ready) ? i_sram_rdata : '0;
        o_timeout    = w_done && w_expire;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (i_ifu_valid && (!i_lsu_valid || r_last)) begin
                r_state <= GNT_IFU;
                r_last  <= 1'b0;
                r_cnt   <= '0;
            end else if (i_lsu_valid) begin
                r_state <= GNT_LSU;
                r_last  <= 1'b1;
                r_cnt   <= '0;
            end
        end else if (w_fin) begin
            r_state <= IDLE;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end
endmodule

// File: tb/tb_ysyx_24090012_sram_arbiter.sv
// tb_ysyx_24090012_sram_arbiter: directed literal checks plus random traffic against a
// transaction-level model (owner, grant age, last winner).
module tb_ysyx_24090012_sram_arbiter;
    localparam int TO = 4;
    localparam int BOUND = 2 * TO + 2;
    logic clk = 1'b0;
    logic rst;
    logic i_ifu_valid, i_lsu_valid, i_lsu_wen, i_sram_ready;
    logic [31:0] i_ifu_addr, i_lsu_addr, i_lsu_wdata, i_sram_rdata;
    logic [3:0] i_lsu_wmask;
    logic o_ifu_ready, o_lsu_ready, o_sram_valid, o_sram_wen, o_busy, o_timeout;
    logic [31:0] o_ifu_rdata, o_lsu_rdata, o_sram_addr, o_sram_wdata;
    logic [3:0] o_sram_wmask;
    int total = 0, bad = 0;
    int m_own = 0, m_age = 0, m_last = 1;
    logic ifu_got = 1'b0, lsu_got = 1'b0;
    int w_ifu = 0, w_lsu = 0;

    always #5 clk = ~clk;

    ysyx_24090012_sram_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_ifu_valid(i_ifu_valid), .i_ifu_addr(i_ifu_addr),
        .o_ifu_ready(o_ifu_ready), .o_ifu_rdata(o_ifu_rdata),
        .i_lsu_valid(i_lsu_valid), .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
        .i_lsu_wmask(i_lsu_wmask), .i_lsu_wen(i_lsu_wen),
        .o_lsu_ready(o_lsu_ready), .o_lsu_rdata(o_lsu_rdata),
        .o_sram_valid(o_sram_valid), .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
        .o_sram_wmask(o_sram_wmask), .o_sram_wen(o_sram_wen),
        .i_sram_ready(i_sram_ready), .i_sram_rdata(i_sram_rdata),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // compare every output against the model, then advance the model one cycle
    task automatic cyc();
        logic busy, expire, done;
        busy   = m_own != 0;
        expire = busy && m_age == TO - 1 && !i_sram_ready;
        done   = busy && (i_sram_ready || expire) && !rst;
        chk("busy", o_busy, busy);
        chk("sram_valid", o_sram_valid, busy);
        chk("sram_addr", o_sram_addr, m_own == 1 ? i_ifu_addr : (m_own == 2 ? i_lsu_addr : 32'h0));
        chk("sram_wdata", o_sram_wdata, m_own == 2 ? i_lsu_wdata : 32'h0);
        chk("sram_wmask", o_sram_wmask, m_own == 2 ? i_lsu_wmask : 4'h0);
        chk("sram_wen", o_sram_wen, m_own == 2 && i_lsu_wen);
        chk("ifu_ready", o_ifu_ready, m_own == 1 && done);
        chk("lsu_ready", o_lsu_ready, m_own == 2 && done);
        chk("ifu_rdata", o_ifu_rdata, (m_own == 1 && done && i_sram_ready) ? i_sram_rdata : 32'h0);
        chk("lsu_rdata", o_lsu_rdata, (m_own == 2 && done && i_sram_ready) ? i_sram_rdata : 32'h0);
        chk("timeout", o_timeout, done && expire);
        chk("both_ready", o_ifu_ready & o_lsu_ready, 0);
        ifu_got = m_own == 1 && done;
        lsu_got = m_own == 2 && done;
        if (rst) begin
            m_own = 0; m_last = 1; m_age = 0;
        end else if (m_own == 0) begin
            if (i_ifu_valid && (!i_lsu_valid || m_last == 1)) begin
                m_own = 1; m_last = 0; m_age = 0;
            end else if (i_lsu_valid) begin
                m_own = 2; m_last = 1; m_age = 0;
            end
        end else if (done) m_own = 0;
        else m_age++;
        @(negedge clk);
    endtask

    task automatic go();
        #1;
        cyc();
    endtask

    initial begin
        rst = 1; i_ifu_valid = 0; i_lsu_valid = 0; i_lsu_wen = 0; i_sram_ready = 0;
        i_ifu_addr = 0; i_lsu_addr = 0; i_lsu_wdata = 0; i_sram_rdata = 0; i_lsu_wmask = 0;
        @(negedge clk);
        go(); go();
        rst = 0; #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_sram_valid", o_sram_valid, 0);
        chk("rst_timeout", o_timeout, 0);
        cyc();
        // IFU read, two-cycle SRAM
        i_ifu_valid = 1; i_ifu_addr = 32'h8000_0000; go();
        #1; chk("rd_c1_valid", o_sram_valid, 1); chk("rd_c1_addr", o_sram_addr, 32'h8000_0000);
        chk("rd_c1_ready", o_ifu_ready, 0); cyc();
        i_sram_ready = 1; i_sram_rdata = 32'h0010_0093;
        #1; chk("rd_c2_ready", o_ifu_ready, 1); chk("rd_c2_rdata", o_ifu_rdata, 32'h0010_0093); cyc();
        i_ifu_valid = 0; i_sram_ready = 0;
        #1; chk("rd_c3_busy", o_busy, 0); cyc();
        // LSU store, then an IFU grant with stale store fields on the LSU inputs
        i_lsu_valid = 1; i_lsu_addr = 32'h8000_1000; i_lsu_wdata = 32'hDEAD_BEEF;
        i_lsu_wmask = 4'b0011; i_lsu_wen = 1; go();
        i_sram_ready = 1;
        #1; chk("st_addr", o_sram_addr, 32'h8000_1000); chk("st_wdata", o_sram_wdata, 32'hDEAD_BEEF);
        chk("st_wmask", o_sram_wmask, 4'b0011); chk("st_wen", o_sram_wen, 1); chk("st_ready", o_lsu_ready, 1);
        cyc();
        i_lsu_valid = 0; i_sram_ready = 0; i_ifu_valid = 1; i_ifu_addr = 32'h8000_0008; go();
        i_sram_ready = 1;
        #1; chk("if_wen", o_sram_wen, 0); chk("if_wmask", o_sram_wmask, 0); chk("if_wdata", o_sram_wdata, 0);
        cyc();
        i_ifu_valid = 0; i_sram_ready = 0; go();
        // simultaneous requests after reset, zero-wait SRAM
        rst = 1; go(); rst = 0;
        i_ifu_valid = 1; i_lsu_valid = 1; i_lsu_wen = 0; i_sram_ready = 1; i_sram_rdata = 32'h1111_2222; go();
        #1; chk("rr_c1_ifu", o_ifu_ready, 1); chk("rr_c1_lsu", o_lsu_ready, 0); cyc();
        #1; chk("rr_c2_idle", o_busy, 0); cyc();
        #1; chk("rr_c3_lsu", o_lsu_ready, 1); chk("rr_c3_rdata", o_lsu_rdata, 32'h1111_2222); cyc();
        go();
        #1; chk("rr_c5_ifu", o_ifu_ready, 1); cyc();
        i_ifu_valid = 0; i_lsu_valid = 0; i_sram_ready = 0; go();
        // watchdog expiry on an LSU load
        i_lsu_valid = 1; go(); go(); go(); go();
        #1; chk("to_fire", o_timeout, 1); chk("to_ready", o_lsu_ready, 1); chk("to_rdata", o_lsu_rdata, 0); cyc();
        i_lsu_valid = 0;
        #1; chk("to_idle", o_busy, 0); cyc();
        // sram_ready on the last watchdog cycle wins
        i_lsu_valid = 1; go(); go(); go(); go();
        i_sram_ready = 1; i_sram_rdata = 32'h1234_5678;
        #1; chk("tw_timeout", o_timeout, 0); chk("tw_ready", o_lsu_ready, 1); chk("tw_rdata", o_lsu_rdata, 32'h1234_5678);
        cyc();
        i_lsu_valid = 0; i_sram_ready = 0; go();
        // reset during an LSU grant
        i_lsu_valid = 1; i_lsu_addr = 32'h8000_2000; go(); go();
        rst = 1; #1; chk("mr_ready", o_lsu_ready, 0); chk("mr_timeout", o_timeout, 0); cyc();
        rst = 0; i_lsu_valid = 0;
        #1; chk("mr_busy", o_busy, 0); chk("mr_sram_valid", o_sram_valid, 0); chk("mr_addr", o_sram_addr, 0); cyc();
        i_ifu_valid = 1; i_ifu_addr = 32'h8000_0004; i_lsu_valid = 1; go();
        i_sram_ready = 1;
        #1; chk("mr_tie_ifu", o_sram_addr, 32'h8000_0004); cyc();
        i_ifu_valid = 0; go(); go();
        i_lsu_valid = 0; i_sram_ready = 0; go();
        // random traffic
        for (int c = 0; c < 10000; c++) begin
            rst = $urandom_range(0, 399) == 0;
            if (!i_ifu_valid || ifu_got) begin
                i_ifu_valid = $urandom_range(0, 2) != 0; i_ifu_addr = $urandom;
            end
            if (!i_lsu_valid || lsu_got) begin
                i_lsu_valid = $urandom_range(0, 2) != 0; i_lsu_addr = $urandom;
                i_lsu_wdata = $urandom; i_lsu_wmask = 4'($urandom); i_lsu_wen = 1'($urandom);
            end
            i_sram_ready = $urandom_range(0, 2) == 0; i_sram_rdata = $urandom;
            go();
            if (rst) begin
                w_ifu = 0; w_lsu = 0;
            end else begin
                if (ifu_got) begin chk("ifu_latency", 32'(w_ifu <= BOUND), 1); w_ifu = 0; end
                else if (i_ifu_valid) w_ifu++;
                if (lsu_got) begin chk("lsu_latency", 32'(w_lsu <= BOUND), 1); w_lsu = 0; end
                else if (i_lsu_valid) w_lsu++;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
